ova_argmax: RTL and testbench
=============================

# ova_argmax

One-vs-all decision stage for the line-buffer logistic-regression classifier. Collects NUM_CLASSES raw inner-product scores (one `hprime` per per-class inner-product unit) in a single handshake. Scans them serially to find the largest signed score, then presents the winning class index and its score through a valid/ready output.

## Interface

Parameters:
- `NUM_CLASSES`, default 10: number of per-class scores; range 2..15.
- `SCORE_W`, default 32: score width, two's-complement.
- `CLASS_W`, default 4: class-index width; must satisfy 2^CLASS_W > NUM_CLASSES.
- `REJECT_THRESH`, default 0: signed SCORE_W-bit reject threshold; used only with ARGMAX_REJECT_EN.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `hprime`, input, SCORE_W x [0:NUM_CLASSES-1]: unpacked array of class scores; index k is class k.
- `in_valid`, input, 1: scores valid.
- `in_ready`, output, 1: block can accept scores.
- `out_class`, output, CLASS_W: winning class index.
- `out_score`, output, SCORE_W: winning score.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: consumer accepts result.

## Operation

- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - `in_ready`=1.
  - When `in_valid`&&`in_ready`, capture all NUM_CLASSES scores into a local score bank and go to SCAN.
  - On the same edge: `idx`=0, `best_score`=hprime[0], `best_idx`=0.
- SCAN:
  - `in_ready`=0. Each cycle compares bank[idx] with `best_score` as a signed comparison.
  - Replace best only if bank[idx] is strictly greater, so ties keep the lowest index.
  - `idx` increments by 1. The cycle that processes idx==NUM_CLASSES-1 transitions to DONE.
- DONE:
  - `out_valid`=1. `out_class`/`out_score` are held stable while `out_valid`=1 and `out_ready`=0.
  - On `out_valid`&&`out_ready`, return to IDLE.
- Input changes after capture have no effect; the bank is written only on an accepted input handshake.
- Arithmetic: comparison only, no accumulation. `out_score` is the unmodified captured value. Most negative value (0x80000000) and most positive value (0x7FFFFFFF) are legal.
- `idx` never wraps. It saturates at NUM_CLASSES-1 and is cleared on capture.

## Timing

- Reset (`rst`=1 at an edge): state=IDLE, `out_valid`=0, `out_class`=0, `out_score`=0, `idx`=0, score bank=0.
- `in_ready`=0 while `rst`=1; `in_ready`=1 in the first cycle after reset deasserts.
- Reset mid-SCAN or mid-DONE aborts the operation: no `out_valid`, the pending result is discarded.
- Latency: input handshake at edge E0, then SCAN edges E1..E(NUM_CLASSES); `out_valid` is high after edge E(NUM_CLASSES). With NUM_CLASSES=10, that is 10 cycles.
- Output handshake at edge D: `out_valid`=0 and `in_ready`=1 after D. There is no same-cycle input/output overlap.
- Maximum throughput: one result per NUM_CLASSES+2 cycles with `out_ready` held at 1.
- `in_ready` is a function of state and `rst` only, never of `in_valid`.
- `out_valid` is a function of state only, never of `out_ready`.

## Configuration

- Macro `ARGMAX_REJECT_EN`.
- Defined: on entry to DONE, if `best_score` is less than REJECT_THRESH (signed), `out_class` is NUM_CLASSES (reject code). In that case `out_score` still carries `best_score`.
- Defined: a score exactly equal to REJECT_THRESH is not rejected.
- Undefined: no reject logic; `out_class` is always in 0..NUM_CLASSES-1 and REJECT_THRESH is ignored.

## Test plan

- Basic argmax: scores {5,-3,12,7,0,1,2,3,4,11}, `out_ready`=1 → `out_class`=2, `out_score`=12, `out_valid` rises 10 cycles after accept.
- Ties and signed compare: all scores 0xFFFFFFF0 (-16) except class 6 and class 8 both 0x00000004 → `out_class`=6.
- Extremes: class 9 = 0x7FFFFFFF, all others 0x80000000 → `out_class`=9, `out_score`=0x7FFFFFFF.
- Backpressure:
  - Hold `out_ready`=0 for 20 cycles → result stays stable and `in_ready` stays 0 throughout.
  - A changed `hprime` with `in_valid` held high is ignored.
  - After `out_ready` pulses, `in_ready`=1 the next cycle, and the next vector is accepted and scored correctly.
- Reset mid-SCAN: assert `rst` for 1 cycle at SCAN idx=4 → `out_valid` stays 0 and `out_class`=0. After reset, a new vector produces the correct result.
- ARGMAX_REJECT_EN with REJECT_THRESH=0:
  - All scores negative, max -1 → `out_class`=10, `out_score`=0xFFFFFFFF.
  - Max exactly 0 → normal class index.

Source files
------------

// File: rtl/ova_argmax.sv
// One-vs-all argmax: captures NUM_CLASSES signed scores, scans them serially, returns winning class/score.
// Optional reject-below-threshold output enabled by defining ARGMAX_REJECT_EN.
module ova_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 32,
    parameter int CLASS_W     = 4,
    parameter logic signed [SCORE_W-1:0] REJECT_THRESH = {SCORE_W{1'b0}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SCORE_W-1:0] hprime [0:NUM_CLASSES-1],
    input  logic               in_valid,
    output logic               in_ready,
    output logic [CLASS_W-1:0] out_class,
    output logic [SCORE_W-1:0] out_score,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CLASS_W-1:0] LAST_IDX  = CLASS_W'(NUM_CLASSES - 1);
    localparam logic [CLASS_W-1:0] IDX_ZERO  = {CLASS_W{1'b0}};
    localparam logic [CLASS_W-1:0] IDX_ONE   = {{(CLASS_W-1){1'b0}}, 1'b1};
    localparam logic [SCORE_W-1:0] SCORE_ZERO = {SCORE_W{1'b0}};

    logic [1:0]               state_r;
    logic [SCORE_W-1:0]       bank_r [0:NUM_CLASSES-1];
    logic [CLASS_W-1:0]       idx_r;
    logic [SCORE_W-1:0]       best_score_r;
    logic [CLASS_W-1:0]       best_idx_r;
    logic [CLASS_W-1:0]       out_class_r;
    logic [SCORE_W-1:0]       out_score_r;
    logic                     out_valid_r;

    logic [SCORE_W-1:0]       cand_s;
    logic                     take_s;
    logic [SCORE_W-1:0]       final_score_s;
    logic [CLASS_W-1:0]       final_idx_s;
    logic                     reject_s;

    // Signed strict-greater so ties keep the earlier (lower) class index
    function automatic logic score_gt(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
        return $signed(a) > $signed(b);
    endfunction

    assign in_ready  = (state_r == ST_IDLE) && !rst;
    assign out_class = out_class_r;
    assign out_score = out_score_r;
    assign out_valid = out_valid_r;

    // Compare the current bank entry against the running best
    always_comb begin
        cand_s        = bank_r[idx_r];
        take_s        = 1'b0;
        final_score_s = best_score_r;
        final_idx_s   = best_idx_r;
        if (score_gt(cand_s, best_score_r)) begin
            take_s        = 1'b1;
            final_score_s = cand_s;
            final_idx_s   = idx_r;
        end else begin
            take_s        = 1'b0;
        end
`ifdef ARGMAX_REJECT_EN
        if (score_gt(REJECT_THRESH, final_score_s)) begin
            reject_s = 1'b1;
        end else begin
            reject_s = 1'b0;
        end
`else
        reject_s = 1'b0;
`endif
    end

`ifndef ARGMAX_REJECT_EN
    logic unused_thresh_s;
    assign unused_thresh_s = ^REJECT_THRESH;
`endif

    // Control FSM, score bank, running best and registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            idx_r        <= IDX_ZERO;
            best_score_r <= SCORE_ZERO;
            best_idx_r   <= IDX_ZERO;
            out_class_r  <= IDX_ZERO;
            out_score_r  <= SCORE_ZERO;
            out_valid_r  <= 1'b0;
            for (int k = 0; k < NUM_CLASSES; k++) begin
                bank_r[k] <= SCORE_ZERO;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < NUM_CLASSES; k++) begin
                            bank_r[k] <= hprime[k];
                        end
                        idx_r        <= IDX_ZERO;
                        best_score_r <= hprime[0];
                        best_idx_r   <= IDX_ZERO;
                        state_r      <= ST_SCAN;
                    end else begin
                        state_r      <= ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    best_score_r <= final_score_s;
                    best_idx_r   <= final_idx_s;
                    if (idx_r == LAST_IDX) begin
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                        out_score_r <= final_score_s;
                        if (reject_s) begin
                            out_class_r <= CLASS_W'(NUM_CLASSES);
                        end else begin
                            out_class_r <= final_idx_s;
                        end
                    end else begin
                        idx_r <= idx_r + IDX_ONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r     <= ST_DONE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ova_argmax.sv
// Self-checking bench for ova_argmax: vector table plus scoreboard, with backpressure and reset corner cases.
module tb_ova_argmax;

    localparam int NC = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] hprime [0:NC-1];
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  out_class;
    logic [31:0] out_score;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int cmp_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [NC-1:0][31:0] sc;
        logic [3:0]          cls;
        logic [31:0]         score;
    } vec_t;

    typedef struct packed {
        logic [3:0]  cls;
        logic [31:0] score;
    } exp_t;

    vec_t tv [8];
    exp_t sb_q [$];

    ova_argmax #(
        .NUM_CLASSES(NC), .SCORE_W(32), .CLASS_W(4), .REJECT_THRESH(32'h0000_0000)
    ) dut (
        .clk(clk), .rst(rst), .hprime(hprime), .in_valid(in_valid), .in_ready(in_ready),
        .out_class(out_class), .out_score(out_score), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // independent reference: signed max, lowest index on ties, reject below 0 when enabled
    function automatic exp_t model(input logic [NC-1:0][31:0] sc);
        exp_t r;
        int b = 0;
        for (int k = 1; k < NC; k++) begin
            if ($signed(sc[k]) > $signed(sc[b])) b = k;
        end
        r.score = sc[b];
        r.cls   = 4'(b);
`ifdef ARGMAX_REJECT_EN
        if ($signed(sc[b]) < 0) r.cls = 4'd10;
`endif
        return r;
    endfunction

    task automatic send(input logic [NC-1:0][31:0] sc, input exp_t e, input bit push);
        int n = 0;
        for (int k = 0; k < NC; k++) hprime[k] = sc[k];
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'(in_ready), 64'd1);
        end else if (push) begin
            sb_q.push_back(e);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic recv(input int hold);
        int n = 0;
        exp_t e;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        chk("latency", 64'(n), 64'd10);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 64'(sb_q.size()), 64'd1);
            e = '0;
        end else begin
            e = sb_q.pop_front();
        end
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            for (int k = 0; k < NC; k++) hprime[k] = 32'h7FFF_FFFF;
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_class", 64'(out_class), 64'(e.cls));
            chk("hold_score", 64'(out_score), 64'(e.score));
            tick();
        end
        chk("out_valid", 64'(out_valid), 64'd1);
        chk("out_class", 64'(out_class), 64'(e.cls));
        chk("out_score", 64'(out_score), 64'(e.score));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("post_valid", 64'(out_valid), 64'd0);
        chk("post_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        exp_t e;
        vec_t v;
        int a0 [NC] = '{5, -3, 12, 7, 0, 1, 2, 3, 4, 11};

        for (int k = 0; k < NC; k++) hprime[k] = 32'h0;

        // vector table
        for (int k = 0; k < NC; k++) tv[0].sc[k] = 32'(a0[k]);
        tv[0].cls = 4'd2; tv[0].score = 32'd12;
        for (int k = 0; k < NC; k++) tv[1].sc[k] = 32'hFFFF_FFF0;
        tv[1].sc[6] = 32'h4; tv[1].sc[8] = 32'h4;
        tv[1].cls = 4'd6; tv[1].score = 32'h4;
        for (int k = 0; k < NC; k++) tv[2].sc[k] = 32'h8000_0000;
        tv[2].sc[9] = 32'h7FFF_FFFF;
        tv[2].cls = 4'd9; tv[2].score = 32'h7FFF_FFFF;
        for (int k = 0; k < NC; k++) tv[3].sc[k] = 32'h8000_0000;
`ifdef ARGMAX_REJECT_EN
        tv[3].cls = 4'd10;
`else
        tv[3].cls = 4'd0;
`endif
        tv[3].score = 32'h8000_0000;
        for (int k = 0; k < NC; k++) tv[4].sc[k] = 32'hFFFF_FFFB;
        tv[4].sc[0] = 32'd100;
        tv[4].cls = 4'd0; tv[4].score = 32'd100;
        for (int k = 0; k < NC; k++) tv[5].sc[k] = 32'hFFFF_FF9C;
        tv[5].sc[3] = 32'hFFFF_FFFF; tv[5].sc[7] = 32'hFFFF_FFFE;
`ifdef ARGMAX_REJECT_EN
        tv[5].cls = 4'd10;
`else
        tv[5].cls = 4'd3;
`endif
        tv[5].score = 32'hFFFF_FFFF;
        for (int k = 0; k < NC; k++) tv[6].sc[k] = 32'hFFFF_FFF8;
        tv[6].sc[5] = 32'h0;
        tv[6].cls = 4'd5; tv[6].score = 32'h0;
        for (int k = 0; k < NC; k++) tv[7].sc[k] = 32'h0;
        tv[7].sc[1] = 32'h7FFF_FFFE; tv[7].sc[2] = 32'h8000_0000;
        tv[7].cls = 4'd1; tv[7].score = 32'h7FFF_FFFE;

        // reset state
        rst = 1'b1;
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_class", 64'(out_class), 64'd0);
        chk("rst_out_score", 64'(out_score), 64'd0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 8; i++) begin
            e.cls = tv[i].cls;
            e.score = tv[i].score;
            send(tv[i].sc, e, 1'b1);
            recv(0);
        end

        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < NC; k++) v.sc[k] = $urandom;
            send(v.sc, model(v.sc), 1'b1);
            recv(0);
        end

        // backpressure with a changing input, then an immediately following vector
        e.cls = tv[0].cls; e.score = tv[0].score;
        send(tv[0].sc, e, 1'b1);
        recv(20);
        e.cls = tv[2].cls; e.score = tv[2].score;
        send(tv[2].sc, e, 1'b1);
        recv(0);

        // reset in the middle of a scan
        e.cls = tv[1].cls; e.score = tv[1].score;
        send(tv[1].sc, e, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        #1;
        chk("midscan_rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("abort_out_class", 64'(out_class), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        begin
            int seen = 0;
            for (int i = 0; i < 15; i++) begin
                if (out_valid) seen++;
                tick();
            end
            chk("abort_no_valid", 64'(seen), 64'd0);
        end
        e.cls = tv[7].cls; e.score = tv[7].score;
        send(tv[7].sc, e, 1'b1);
        recv(0);

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
